// File: rtl/code_lock_pkg.sv
// Shared types and helpers for the code lock controller.
// The LOCKOUT state exists only when CODE_LOCK_LOCKOUT_EN is defined.
package code_lock_pkg;

`ifdef CODE_LOCK_LOCKOUT_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_OPEN  = 3'd2,
    ST_FAIL  = 3'd3
  } state_e;
`endif

  // LEDs are active-low; the top slices these down to LED_W.
  localparam int                   LED_MAX_W   = 32;
  localparam logic [LED_MAX_W-1:0] LED_ALL_ON  = '0;
  localparam logic [LED_MAX_W-1:0] LED_ALL_OFF = '1;

  // Bits needed to hold one digit index.
  function automatic int key_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Index of the lowest set key bit; higher simultaneous keys are dropped.
  function automatic int key_enc(input logic [7:0] k);
    int idx;
    idx = 0;
    for (int i = 7; i >= 0; i--) begin
      if (k[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/code_lock_timer.sv
// Loadable down-counter shared by the OPEN, FAIL and LOCKOUT phases.
// Loading N gives a one-cycle done pulse N+1 cycles later; a load in the
// done cycle restarts it seamlessly.
module code_lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;
  logic         r_run;

  // Count down while running; stop after reaching zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_val;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) r_run <= 1'b0;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = r_run & (r_cnt == '0);

endmodule

// File: rtl/code_lock_ctrl.sv
// Digit-code lock controller: collects key digits, checks them on confirm,
// then holds open, flashes a failure pattern, or (with
// CODE_LOCK_LOCKOUT_EN defined) raises an alarm lockout after repeated fails.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int NUM_KEYS = 3,
  parameter int CODE_LEN = 4,
  parameter logic [CODE_LEN*key_w(NUM_KEYS)-1:0] CODE = {2'd1, 2'd0, 2'd2, 2'd1},
  parameter int LED_W     = 4,
  parameter int OPEN_CYC  = 50_000_000,
  parameter int FLASH_CYC = 12_500_000,
  parameter int FLASH_NUM = 6,
  parameter int MAX_FAIL  = 3,
  parameter int LOCK_CYC  = 250_000_000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_KEYS-1:0]             key_in,
  input  logic                            okay_in,
  output logic [LED_W-1:0]                led_control,
  output logic                            unlocked,
  output logic                            alarm,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int KEY_W = key_w(NUM_KEYS);
  localparam int CNT_W = $clog2(CODE_LEN + 1);
  localparam int FC_W  = $clog2(MAX_FAIL + 1);
  localparam int FL_W  = $clog2(FLASH_NUM + 1);
  localparam int TMR_W = $clog2(max3(OPEN_CYC, FLASH_CYC, LOCK_CYC) + 1);

  localparam logic [LED_W-1:0] LED_ON    = LED_ALL_ON[LED_W-1:0];
  localparam logic [LED_W-1:0] LED_OFF   = LED_ALL_OFF[LED_W-1:0];
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CODE_LEN);
  localparam logic [FC_W-1:0]  FC_MAX    = FC_W'(MAX_FAIL);
  localparam logic [FL_W-1:0]  FL_MAX    = FL_W'(FLASH_NUM);
  localparam logic [TMR_W-1:0] T_OPEN    = TMR_W'(OPEN_CYC - 1);
  localparam logic [TMR_W-1:0] T_FLASH   = TMR_W'(FLASH_CYC - 1);
`ifdef CODE_LOCK_LOCKOUT_EN
  localparam logic [TMR_W-1:0] T_LOCK    = TMR_W'(LOCK_CYC - 1);
  // Only the top LED lit during lockout.
  localparam logic [LED_W-1:0] LED_LOCK  = LED_OFF ^ (LED_W'(1) << (LED_W - 1));
`endif

  state_e                             r_state, w_state;
  logic [CNT_W-1:0]                   r_cnt, w_cnt;
  logic [CODE_LEN-1:0][KEY_W-1:0]     r_buf, w_buf;
  logic                               r_ovf, w_ovf;
  logic [FL_W-1:0]                    r_flash, w_flash;
  logic [LED_W-1:0]                   r_led, w_led;
  logic                               r_unl, w_unl;
  logic [FC_W-1:0]                    r_fcnt, w_fcnt;
`ifdef CODE_LOCK_LOCKOUT_EN
  logic                               r_alarm, w_alarm;
`endif

  logic [KEY_W-1:0]                   w_key;
  logic                               w_pass;
  logic                               w_tload;
  logic [TMR_W-1:0]                   w_tval;
  logic                               w_done;

  assign w_key  = KEY_W'(key_enc(8'(key_in)));
  assign w_pass = (r_cnt == CNT_FULL) & ~r_ovf & (r_buf == CODE);

  code_lock_timer #(.W(TMR_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_tload),
    .i_val  (w_tval),
    .o_done (w_done)
  );

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_buf   = r_buf;
    w_ovf   = r_ovf;
    w_flash = r_flash;
    w_led   = r_led;
    w_unl   = r_unl;
    w_fcnt  = r_fcnt;
    w_tload = 1'b0;
    w_tval  = '0;
`ifdef CODE_LOCK_LOCKOUT_EN
    w_alarm = r_alarm;
`endif
    case (r_state)
      ST_IDLE, ST_ENTRY: begin
        if (okay_in) begin
          // Confirm beats any key in the same cycle; buffer always cleared.
          w_cnt   = '0;
          w_buf   = '0;
          w_ovf   = 1'b0;
          w_led   = LED_ON;
          w_tload = 1'b1;
          if (w_pass) begin
            w_state = ST_OPEN;
            w_unl   = 1'b1;
            w_fcnt  = '0;
            w_tval  = T_OPEN;
          end else begin
            w_state = ST_FAIL;
            w_flash = '0;
            w_tval  = T_FLASH;
            if (r_fcnt != FC_MAX) w_fcnt = r_fcnt + 1'b1;
          end
        end else if (|key_in) begin
          w_state = ST_ENTRY;
          if (r_cnt == CNT_FULL) begin
            w_ovf = 1'b1;
          end else begin
            for (int j = 0; j < CODE_LEN; j++) begin
              if (CNT_W'(j) == r_cnt) w_buf[j] = w_key;
            end
            w_cnt = r_cnt + 1'b1;
          end
          // Thermometer: one lit LED per stored digit.
          for (int j = 0; j < LED_W; j++) begin
            w_led[j] = (j < int'(w_cnt)) ? 1'b0 : 1'b1;
          end
        end
      end
      ST_OPEN: begin
        if (w_done) begin
          w_state = ST_IDLE;
          w_unl   = 1'b0;
          w_led   = LED_OFF;
        end
      end
      ST_FAIL: begin
        if (w_done) begin
          if (r_flash != FL_MAX) begin
            w_led   = ~r_led;
            w_flash = r_flash + 1'b1;
            w_tload = 1'b1;
            w_tval  = T_FLASH;
          end else begin
`ifdef CODE_LOCK_LOCKOUT_EN
            if (r_fcnt == FC_MAX) begin
              w_state = ST_LOCKOUT;
              w_alarm = 1'b1;
              w_led   = LED_LOCK;
              w_tload = 1'b1;
              w_tval  = T_LOCK;
            end else begin
              w_state = ST_IDLE;
              w_led   = LED_OFF;
            end
`else
            w_state = ST_IDLE;
            w_led   = LED_OFF;
`endif
          end
        end
      end
`ifdef CODE_LOCK_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (w_done) begin
          w_state = ST_IDLE;
          w_alarm = 1'b0;
          w_led   = LED_OFF;
          w_fcnt  = '0;
        end
      end
`endif
      default: begin
        w_state = ST_IDLE;
        w_led   = LED_OFF;
        w_unl   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_ovf   <= 1'b0;
      r_flash <= '0;
      r_led   <= LED_OFF;
      r_unl   <= 1'b0;
      r_fcnt  <= '0;
`ifdef CODE_LOCK_LOCKOUT_EN
      r_alarm <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_buf   <= w_buf;
      r_ovf   <= w_ovf;
      r_flash <= w_flash;
      r_led   <= w_led;
      r_unl   <= w_unl;
      r_fcnt  <= w_fcnt;
`ifdef CODE_LOCK_LOCKOUT_EN
      r_alarm <= w_alarm;
`endif
    end
  end

  assign led_control = r_led;
  assign unlocked    = r_unl;
  assign fail_cnt    = r_fcnt;
`ifdef CODE_LOCK_LOCKOUT_EN
  assign alarm       = r_alarm;
`else
  assign alarm       = 1'b0;
`endif

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Scoreboard bench for code_lock_ctrl: stimulus pushes the expected
// registered outputs for every edge it drives; a negedge monitor pops and
// compares. Covers both CODE_LOCK_LOCKOUT_EN builds.
module tb_code_lock_ctrl;
  localparam int OC = 10;
  localparam int FC = 4;
  localparam int FN = 6;
  localparam int LC = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key_in = '0;
  logic       okay_in = 1'b0;
  logic [3:0] led_control;
  logic       unlocked;
  logic       alarm;
  logic [1:0] fail_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] led;
    logic       unl;
    logic       alm;
    logic [1:0] fc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  string phase = "reset";
  logic [1:0] fc_now;

  code_lock_ctrl #(
    .OPEN_CYC (OC),
    .FLASH_CYC(FC),
    .FLASH_NUM(FN),
    .LOCK_CYC (LC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .okay_in    (okay_in),
    .led_control(led_control),
    .unlocked   (unlocked),
    .alarm      (alarm),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  // One clock edge with the given inputs; expected outputs after that edge.
  task automatic cyc(input logic [2:0] k, input logic ok, input logic [3:0] led,
                     input logic unl, input logic alm, input logic [1:0] fc);
    key_in  = k;
    okay_in = ok;
    @(posedge clk);
    exp_q.push_back({led, unl, alm, fc});
    tag_q.push_back(phase);
    #1;
    key_in  = '0;
    okay_in = 1'b0;
  endtask

  task automatic enter4(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                        input logic [2:0] d, input logic [1:0] fc);
    cyc(a, 1'b0, 4'b1110, 1'b0, 1'b0, fc);
    cyc(b, 1'b0, 4'b1100, 1'b0, 1'b0, fc);
    cyc(c, 1'b0, 4'b1000, 1'b0, 1'b0, fc);
    cyc(d, 1'b0, 4'b0000, 1'b0, 1'b0, fc);
  endtask

  // Confirm that passes: OC cycles open (keys/okay ignored), then idle.
  task automatic open_seq();
    cyc(3'b000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0);
    for (int i = 1; i < OC; i++)
      cyc((i % 2) ? 3'b001 : 3'b000, (i == 4), 4'b0000, 1'b1, 1'b0, 2'd0);
    cyc(3'b000, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0);
  endtask

  // Confirm that fails: FN inversions every FC cycles plus a final FC hold.
  // Exit cycle is left to the caller.
  task automatic fail_seq(input logic [2:0] k, input logic [1:0] fc);
    cyc(k, 1'b1, 4'b0000, 1'b0, 1'b0, fc);
    for (int i = 1; i < FC * (FN + 1); i++)
      cyc((i % 3 == 0) ? 3'b001 : 3'b000, (i == 7),
          (((i / FC) % 2) != 0) ? 4'b1111 : 4'b0000, 1'b0, 1'b0, fc);
  endtask

  // Monitor: compare registered outputs once per cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if ({led_control, unlocked, alarm, fail_cnt} !== e) begin
          errors++;
          $display("FAIL %s: got led=%b unl=%b alm=%b fc=%0d, expected led=%b unl=%b alm=%b fc=%0d",
                   t, led_control, unlocked, alarm, fail_cnt, e.led, e.unl, e.alm, e.fc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end (checks=%0d)", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, with a confirm during reset that must be ignored.
    rst_n = 1'b0;
    cyc(3'b000, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0);
    cyc(3'b001, 1'b1, 4'b1111, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;
    phase = "idle";
    cyc(3'b000, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0);

    // Correct code 1,2,0,1.
    phase = "pass";
    enter4(3'b010, 3'b100, 3'b001, 3'b010, 2'd0);
    open_seq();

    // Wrong last digit.
    phase = "wrong_code";
    enter4(3'b010, 3'b100, 3'b001, 3'b100, 2'd0);
    fail_seq(3'b000, 2'd1);
    cyc(3'b000, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd1);

    // Five digits: correct prefix plus an overflow digit.
    phase = "overflow";
    cyc(3'b010, 1'b0, 4'b1110, 1'b0, 1'b0, 2'd1);
    cyc(3'b100, 1'b0, 4'b1100, 1'b0, 1'b0, 2'd1);
    cyc(3'b001, 1'b0, 4'b1000, 1'b0, 1'b0, 2'd1);
    cyc(3'b010, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1);
    cyc(3'b010, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1);
    fail_seq(3'b000, 2'd2);
    cyc(3'b000, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd2);

    // Confirm with no digits: third consecutive failure.
    phase = "empty_okay";
    fail_seq(3'b000, 2'd3);
`ifdef CODE_LOCK_LOCKOUT_EN
    phase = "lockout";
    for (int i = 0; i < LC; i++)
      cyc((i % 2) ? 3'b010 : 3'b000, (i == 3), 4'b0111, 1'b0, 1'b1, 2'd3);
    cyc(3'b000, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0);
    phase = "after_lockout";
    fail_seq(3'b000, 2'd1);
    cyc(3'b000, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd1);
    fc_now = 2'd1;
`else
    cyc(3'b000, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd3);
    phase = "saturate";
    fail_seq(3'b000, 2'd3);
    cyc(3'b000, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd3);
    fc_now = 2'd3;
`endif

    // Multi-bit keys take the lowest set bit: 110->1, 100->2, 011->0, 010->1.
    phase = "multi_key";
    enter4(3'b110, 3'b100, 3'b011, 3'b010, fc_now);
    open_seq();

    // Key arriving with confirm is dropped: three digits only -> fail.
    phase = "key_with_okay";
    cyc(3'b010, 1'b0, 4'b1110, 1'b0, 1'b0, 2'd0);
    cyc(3'b100, 1'b0, 4'b1100, 1'b0, 1'b0, 2'd0);
    cyc(3'b001, 1'b0, 4'b1000, 1'b0, 1'b0, 2'd0);
    fail_seq(3'b110, 2'd1);
    cyc(3'b000, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd1);

    // Reset in the middle of OPEN aborts at once, no leftover timer effect.
    phase = "reset_in_open";
    enter4(3'b010, 3'b100, 3'b001, 3'b010, 2'd1);
    cyc(3'b000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0);
    cyc(3'b000, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0);
    cyc(3'b000, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0);
    rst_n = 1'b0;
    cyc(3'b000, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;
    phase = "post_reset";
    for (int i = 0; i < OC + 2; i++)
      cyc(3'b000, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
